uart_rx_deframer: RTL
=====================

Name: uart_rx_deframer

Overview:
Serial-to-parallel UART receive stage, directly downstream of the UART transmitter. It samples the serial line at mid-bit, checks parity and stop bit, and presents each received byte as a one-cycle valid/data_out/burst_id word for the output monitor and scoreboard path. Frames separated by a line-idle gap longer than a threshold are tagged with a new burst_id.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit time; must be even and at least 4
DATA_W, 8, data bits per frame, sent LSB first
BURST_W, 4, burst_id width
PARITY_EN, 1, 1 means a parity bit follows the data bits
PARITY_ODD, 0, 0 means even parity, 1 means odd parity
IDLE_GAP_BITS, 2, line-high bit times in IDLE that close a burst

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
rx_serial  in  1  asynchronous serial line; idles high
valid  out  1  one-cycle pulse; a frame has completed
data_out  out  DATA_W  received data; held until the next valid
burst_id  out  BURST_W  burst tag of the current frame; held with data_out
parity_err  out  1  qualified by valid; parity mismatch
frame_err  out  1  qualified by valid; stop bit sampled low
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: reset=0 on a clk edge. All outputs go to 0 on the next edge. State goes to IDLE. Synchronizer flops go to 1. Internal burst counter goes to all-ones. gap flag goes to 1.
- rx_serial passes through a 2-flop synchronizer (rx_s). A start is a falling edge of rx_s seen in IDLE.
- States:
  - IDLE: on a start, go to START and clear the bit-time counter.
  - START: at count CLKS_PER_BIT/2-1, sample rx_s.
    - If rx_s=1, treat it as a glitch and return to IDLE; no valid pulse.
    - Otherwise reset the counter and go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles. Shift bits in LSB first. After DATA_W samples, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: sample one bit. parity_err_next = XOR(data bits, parity bit) XOR PARITY_ODD.
  - STOP: sample one bit.
    - On the next edge: valid=1, data_out, burst_id, parity_err, frame_err=!sample all update. Then go to IDLE.
    - A frame with an error still produces valid=1, with the error flag set.
- valid is high for exactly one cycle per completed frame. It is never asserted for a rejected glitch.
- Latency: t0 is the first edge at which the rx_serial low is registered. valid is high at edge t0 + 2 + CLKS_PER_BIT/2 + (DATA_W + PARITY_EN + 1)*CLKS_PER_BIT, which is 170 with the defaults.
- Frame error with the line held low (break): the FSM returns to IDLE. A new start needs a fresh falling edge, so no spurious frames are produced.
- Burst tagging:
  - In IDLE, an idle counter counts consecutive cycles with rx_s=1. It saturates, and clears when rx_s=0.
  - When the idle counter reaches IDLE_GAP_BITS*CLKS_PER_BIT, set the gap flag.
  - On entry to DATA with the gap flag set, increment the burst counter (wraps mod 2^BURST_W) and clear the gap flag.
  - The first frame after reset therefore carries burst_id=0. Back-to-back frames with gaps below the threshold share a burst_id.
- Reset mid-frame: abort immediately. No valid pulse. The next frame is treated as burst 0.
- Simultaneous reset and a completing STOP: reset wins.
- The bit-time counter width is $clog2(CLKS_PER_BIT). The idle counter width is $clog2(IDLE_GAP_BITS*CLKS_PER_BIT+1).

Decomposition:
- Shared package uart_rx_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - rx_status_t struct {parity_err, frame_err}
  - the localparam for the default CLKS_PER_BIT
- One sub-module, uart_rx_sync: 2-flop synchronizer plus falling-edge detect. It is reset to 1 under the same active-low synchronous reset.

Test Plan:
- Even parity: send 0xA5 with parity bit 0 and stop bit 1 -> valid at t0+170, data_out=0xA5, parity_err=0, frame_err=0, burst_id=0.
- Parity error: send 0x3C with parity bit 1 -> valid pulses, data_out=0x3C, parity_err=1, frame_err=0.
- Framing error: send 0xFF with stop bit 0, then hold the line low for 5 bit times -> one valid with frame_err=1. No further valid until a new falling edge arrives.
- Glitch rejection: a 4-cycle low pulse on rx_serial -> busy pulses, valid never asserts, state returns to IDLE.
- Burst tagging:
  - Send 0x11, 0x22 back-to-back, then a 3-bit-time idle, then 0x33 -> burst_id 0, 0, 1.
  - Repeat until 17 bursts have been sent -> burst_id wraps to 0.
- Reset mid-frame: assert reset=0 during DATA bit 4 of 0x5A, release, then send 0x5A -> exactly one valid, with data_out=0x5A and burst_id=0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive deframer.
// States, frame status bundle and default timing.
`timescale 1ns/1ps
package uart_rx_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
    } rx_status_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line.
// Also flags a falling edge of the synchronized line.
`timescale 1ns/1ps
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    // [0],[1] synchronize; [2] holds the previous synced value
    logic [2:0] sh_q;

    // Shift the line in; idle-high after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_q <= 3'b111;
        end else begin
            sh_q <= {sh_q[1:0], rx_i};
        end
    end

    assign rx_s_o = sh_q[1];
    assign fall_o = sh_q[2] & ~sh_q[1];

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: mid-bit sampling, parity/stop
// checks, and idle-gap based burst tagging.
`timescale 1ns/1ps
module uart_rx_deframer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
    parameter int DATA_W        = 8,
    parameter int BURST_W       = 4,
    parameter int PARITY_EN     = 1,
    parameter int PARITY_ODD    = 0,
    parameter int IDLE_GAP_BITS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_serial,
    output logic               valid,
    output logic [DATA_W-1:0]  data_out,
    output logic [BURST_W-1:0] burst_id,
    output logic               parity_err,
    output logic               frame_err,
    output logic               busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int BW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP = IDLE_GAP_BITS * CLKS_PER_BIT;
    localparam int IW  = $clog2(GAP + 1);

    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST    = BW'(DATA_W - 1);
    localparam logic [IW-1:0] GAP_CNT = IW'(GAP);
    localparam logic          ODD     = (PARITY_ODD != 0);
    localparam logic          PAR_ON  = (PARITY_EN != 0);

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .rx_i   (rx_serial),
        .rx_s_o (rx_s),
        .fall_o (fall)
    );

    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              perr_q, perr_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic              gap_q, gap_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BURST_W-1:0] bid_q, bid_d;
    rx_status_t        status_q, status_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            perr_q   <= 1'b0;
            idle_q   <= '0;
            gap_q    <= 1'b1;
            burst_q  <= '1;
            valid_q  <= 1'b0;
            data_q   <= '0;
            bid_q    <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            perr_q   <= perr_d;
            idle_q   <= idle_d;
            gap_q    <= gap_d;
            burst_q  <= burst_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            bid_q    <= bid_d;
            status_q <= status_d;
        end
    end

    // Next-state: frame sequencing, sampling, burst tracking
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        idle_d   = '0;
        gap_d    = gap_q;
        burst_d  = burst_q;
        valid_d  = 1'b0;
        data_d   = data_q;
        bid_d    = bid_q;
        status_d = status_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    idle_d = '0;
                end else if (idle_q != GAP_CNT) begin
                    idle_d = idle_q + 1'b1;
                end else begin
                    idle_d = idle_q;
                end
                if (idle_q == GAP_CNT) begin
                    gap_d = 1'b1;
                end
                if (fall) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        if (gap_q) begin
                            burst_d = burst_q + 1'b1;
                            gap_d   = 1'b0;
                        end
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    shift_d = shift_q >> 1;
                    shift_d[DATA_W-1] = rx_s;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == LAST) begin
                        state_d = PAR_ON ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    perr_d  = (^shift_q) ^ rx_s ^ ODD;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    valid_d             = 1'b1;
                    data_d              = shift_q;
                    bid_d               = burst_q;
                    status_d.parity_err = perr_q;
                    status_d.frame_err  = ~rx_s;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign valid      = valid_q;
    assign data_out   = data_q;
    assign burst_id   = bid_q;
    assign parity_err = status_q.parity_err;
    assign frame_err  = status_q.frame_err;
    assign busy       = (state_q != IDLE);

endmodule
